ds1302_engine: RTL

Parametrised DS1302 three-wire transaction engine. It replaces the separate read and write controllers and the external CE/IO muxing with one arbitrated FSM. The engine generates its own SCLK and handles single-byte writes, single-byte reads and N-byte clock-burst reads. It sits between rtcCtrl/UART-side requesters and the DS1302 pins; the top level only instantiates the tristate buffer from ioOut/ioOe.

---
 rtl/ds1302_pkg.sv | 35 +++
 rtl/ds1302_engine_if.sv | 31 +++
 rtl/ds1302_shifter.sv | 46 ++++
 rtl/ds1302_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ds1302_pkg.sv
// Shared types and command-byte layout for the DS1302 three-wire engine.
package ds1302_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_HOLD,
        ST_RECOVER
    } state_e;

    typedef enum logic [1:0] {
        OP_WR,
        OP_RD,
        OP_BURST
    } op_e;

    localparam logic [7:0] CMD_BURST_RD  = 8'hBF;
    localparam int         CMD_RAM_BIT   = 6;
    localparam int         CMD_RNW_BIT   = 0;
    localparam int         MAX_BURST_LEN = 8;

    // Command byte: {1, ram, addr[4:0], rnw}
    function automatic logic [7:0] make_cmd(input logic [5:0] addr, input logic rnw);
        logic [7:0] c;
        c              = 8'h80;
        c[CMD_RAM_BIT] = addr[5];
        c[5:1]         = addr[4:0];
        c[CMD_RNW_BIT] = rnw;
        return c;
    endfunction

endpackage

// File: rtl/ds1302_engine_if.sv
// Requester-side and pin-side signals of the DS1302 engine.
interface ds1302_engine_if #(
    parameter int BURST_LEN = 7
);
    logic                   wrReq;
    logic [5:0]             wrAddr;
    logic [7:0]             wrData;
    logic                   rdReq;
    logic [5:0]             rdAddr;
    logic                   burstReq;
    logic                   busy;
    logic                   done;
    logic [7:0]             rdData;
    logic [8*BURST_LEN-1:0] burstData;
    logic                   burstValid;
    logic                   sclk;
    logic                   ce;
    logic                   ioOut;
    logic                   ioOe;
    logic                   ioIn;

    modport slave (
        input  wrReq, wrAddr, wrData, rdReq, rdAddr, burstReq, ioIn,
        output busy, done, rdData, burstData, burstValid, sclk, ce, ioOut, ioOe
    );

    modport master (
        output wrReq, wrAddr, wrData, rdReq, rdAddr, burstReq, ioIn,
        input  busy, done, rdData, burstData, burstValid, sclk, ce, ioOut, ioOe
    );
endinterface

// File: rtl/ds1302_shifter.sv
// LSB-first 8-bit shift register shared by transmit and receive, with bit counter.
module ds1302_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       step_i,
    input  logic       tx_i,
    input  logic       capture_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       next_bit_o,
    output logic       last_o
);
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = load_val_i;
            cnt_d = 3'd0;
        end else if (capture_i) begin
            sr_d = {rx_i, sr_q[7:1]};
        end else if (step_i) begin
            // The counter advances once per SCLK period, at the end of its high half
            cnt_d = cnt_q + 3'd1;
            if (tx_i) sr_d = {1'b0, sr_q[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o     = sr_q;
    assign next_bit_o = sr_q[1];
    assign last_o     = (cnt_q == 3'd7);
endmodule

// File: rtl/ds1302_engine.sv
// Arbitrated DS1302 transaction engine: single write, single read and clock-burst read.
module ds1302_engine
    import ds1302_pkg::*;
#(
    parameter int CLK_DIV   = 100,
    parameter int CE_GUARD  = 400,
    parameter int BURST_LEN = 7
) (
    input  logic           clk,
    input  logic           rst,
    ds1302_engine_if.slave bus
);
    localparam int TMAX = (CE_GUARD > CLK_DIV) ? CE_GUARD : CLK_DIV;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(MAX_BURST_LEN);
    localparam int DW   = 8 * BURST_LEN;
    localparam logic [TW-1:0] GUARD_LAST = TW'(CE_GUARD - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            half_q, half_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [DW-1:0]   coll_q, coll_d;
    logic            sclk_q, sclk_d;
    logic            ce_q, ce_d;
    logic            oe_q, oe_d;
    logic            iout_q, iout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            bvalid_q, bvalid_d;
    logic [7:0]      rd_q, rd_d;
    logic [DW-1:0]   bd_q, bd_d;
    logic            io_s1_q, io_s2_q;

    logic            sh_load, sh_step, sh_tx, sh_cap;
    logic [7:0]      sh_val, sh_data;
    logic            sh_next, sh_last;
    logic            guard_end, half_end;
    logic [BW-1:0]   last_byte;

    ds1302_shifter u_shift (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sh_load),
        .load_val_i (sh_val),
        .step_i     (sh_step),
        .tx_i       (sh_tx),
        .capture_i  (sh_cap),
        .rx_i       (io_s2_q),
        .data_o     (sh_data),
        .next_bit_o (sh_next),
        .last_o     (sh_last)
    );

    assign guard_end = (tmr_q == GUARD_LAST);
    assign half_end  = (tmr_q == HALF_LAST);
    assign last_byte = (op_q == OP_BURST) ? BURST_LAST : '0;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tmr_d    = tmr_q + 1'b1;
        half_d   = half_q;
        byte_d   = byte_q;
        cmd_d    = cmd_q;
        wdata_d  = wdata_q;
        coll_d   = coll_q;
        sclk_d   = sclk_q;
        ce_d     = ce_q;
        oe_d     = oe_q;
        iout_d   = iout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bvalid_d = 1'b0;
        rd_d     = rd_q;
        bd_d     = bd_q;
        sh_load  = 1'b0;
        sh_val   = '0;
        sh_step  = 1'b0;
        sh_tx    = 1'b0;
        sh_cap   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                // Fixed priority: write, then burst, then single read
                if (bus.wrReq || bus.burstReq || bus.rdReq) begin
                    state_d = ST_SETUP;
                    busy_d  = 1'b1;
                    ce_d    = 1'b1;
                    wdata_d = bus.wrData;
                    if (bus.wrReq) begin
                        op_d  = OP_WR;
                        cmd_d = make_cmd(bus.wrAddr, 1'b0);
                    end else if (bus.burstReq) begin
                        op_d  = OP_BURST;
                        cmd_d = CMD_BURST_RD;
                    end else begin
                        op_d  = OP_RD;
                        cmd_d = make_cmd(bus.rdAddr, 1'b1);
                    end
                end
            end

            ST_SETUP: begin
                if (guard_end) begin
                    state_d = ST_CMD;
                    tmr_d   = '0;
                    half_d  = 1'b0;
                    sclk_d  = 1'b0;
                    oe_d    = 1'b1;
                    iout_d  = cmd_q[0];
                    sh_load = 1'b1;
                    sh_val  = cmd_q;
                end
            end

            ST_CMD, ST_WDATA, ST_RDATA: begin
                if (half_end) begin
                    tmr_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sclk_d = 1'b1;
                        sh_cap = (state_q == ST_RDATA);
                    end else begin
                        half_d  = 1'b0;
                        sclk_d  = 1'b0;
                        sh_step = 1'b1;
                        sh_tx   = (state_q != ST_RDATA);
                        if (!sh_last) begin
                            if (state_q != ST_RDATA) iout_d = sh_next;
                        end else if (state_q == ST_CMD) begin
                            if (op_q == OP_WR) begin
                                state_d = ST_WDATA;
                                sh_load = 1'b1;
                                sh_val  = wdata_q;
                                iout_d  = wdata_q[0];
                            end else begin
                                // Release the pin before the device starts driving
                                state_d = ST_RDATA;
                                oe_d    = 1'b0;
                                iout_d  = 1'b0;
                                byte_d  = '0;
                            end
                        end else if (state_q == ST_WDATA) begin
                            state_d = ST_HOLD;
                            oe_d    = 1'b0;
                            iout_d  = 1'b0;
                        end else begin
                            coll_d[8*byte_q +: 8] = sh_data;
                            if (byte_q == last_byte) state_d = ST_HOLD;
                            else                     byte_d  = byte_q + 1'b1;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (guard_end) begin
                    // Results are published only once the whole transaction has finished
                    state_d = ST_RECOVER;
                    tmr_d   = '0;
                    ce_d    = 1'b0;
                    done_d  = 1'b1;
                    if (op_q == OP_RD) rd_d = sh_data;
                    if (op_q == OP_BURST) begin
                        bd_d     = coll_q;
                        bvalid_d = 1'b1;
                    end
                end
            end

            ST_RECOVER: begin
                if (guard_end) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_WR;
            tmr_q    <= '0;
            half_q   <= 1'b0;
            byte_q   <= '0;
            cmd_q    <= '0;
            wdata_q  <= '0;
            coll_q   <= '0;
            sclk_q   <= 1'b0;
            ce_q     <= 1'b0;
            oe_q     <= 1'b0;
            iout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bvalid_q <= 1'b0;
            rd_q     <= '0;
            bd_q     <= '0;
            io_s1_q  <= 1'b0;
            io_s2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tmr_q    <= tmr_d;
            half_q   <= half_d;
            byte_q   <= byte_d;
            cmd_q    <= cmd_d;
            wdata_q  <= wdata_d;
            coll_q   <= coll_d;
            sclk_q   <= sclk_d;
            ce_q     <= ce_d;
            oe_q     <= oe_d;
            iout_q   <= iout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bvalid_q <= bvalid_d;
            rd_q     <= rd_d;
            bd_q     <= bd_d;
            io_s1_q  <= bus.ioIn;
            io_s2_q  <= io_s1_q;
        end
    end

    assign bus.sclk       = sclk_q;
    assign bus.ce         = ce_q;
    assign bus.ioOe       = oe_q;
    assign bus.ioOut      = iout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.burstValid = bvalid_q;
    assign bus.rdData     = rd_q;
    assign bus.burstData  = bd_q;
endmodule
